// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register-bank slave.
// Optional byte-strobe writes are enabled with APB_REGBANK_PSTRB_EN.
package apb_regbank_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} fsm_state_e;

  // Bytes per word on the default 32-bit bus; narrower buses pass their own width.
  localparam int BYTES_PER_WORD = 4;

  function automatic logic [63:0] addr_to_idx(input logic [63:0] offset,
                                              input int bytesPerWord = BYTES_PER_WORD);
    case (bytesPerWord)
      1:       addr_to_idx = offset;
      2:       addr_to_idx = offset >> 1;
      default: addr_to_idx = offset >> 2;
    endcase
  endfunction

endpackage

// File: rtl/apb_regbank_decoder.sv
// Combinational address decode: byte address to word index, range/alignment hit,
// and read-only write detection.
module apb_regbank_decoder
  import apb_regbank_pkg::*;
#(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        NUM_REGS       = 8,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [NUM_REGS-1:0]       RO_MASK        = '0,
  localparam int                       IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic                      pwrite,
  output logic [IDX_W-1:0]          idx,
  output logic                      hit,
  output logic                      ro_err
);

  localparam int WORD_BYTES = APB_DATA_WIDTH / 8;

  logic [APB_ADDR_WIDTH-1:0] offset;
  logic [63:0]               wordIdx;
  logic                      aligned;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  always_comb begin
    offset  = paddr - BASE_ADDR;
    wordIdx = addr_to_idx(64'(offset), WORD_BYTES);
    aligned = (64'(offset) & 64'(WORD_BYTES - 1)) == 64'd0;
    hit     = aligned && (wordIdx < 64'(NUM_REGS));
    idx     = IDX_W'(wordIdx);
    ro_err  = hit && pwrite && RO_MASK[idx];
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave with a word register bank, wait states, error response and RO status words.
// Define APB_REGBANK_PSTRB_EN to honour pstrb byte strobes on writes.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        NUM_REGS       = 8,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [NUM_REGS-1:0]       RO_MASK        = '0,
  parameter int                        WAIT_STATES    = 0,
  parameter logic [APB_DATA_WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [APB_ADDR_WIDTH-1:0]          paddr,
  input  logic                               psel,
  input  logic                               penable,
  input  logic                               pwrite,
  input  logic [APB_DATA_WIDTH-1:0]          pwdata,
  input  logic [APB_DATA_WIDTH/8-1:0]        pstrb,
  output logic [APB_DATA_WIDTH-1:0]          prdata,
  output logic                               pready,
  output logic                               pslverr,
  output logic [NUM_REGS*APB_DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*APB_DATA_WIDTH-1:0] sts_in,
  output logic [NUM_REGS-1:0]                wr_pulse
);

  localparam int STRB_W = APB_DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  fsm_state_e                               state;
  logic [3:0]                               cnt;
  logic [IDX_W-1:0]                         idxQ, decIdx, rdIdx;
  logic                                     writeQ, errQ;
  logic                                     decHit, decRoErr, decErr;
  logic [NUM_REGS-1:0][APB_DATA_WIDTH-1:0]  regs, sts;
  logic [APB_DATA_WIDTH-1:0]                rdData;
  logic [STRB_W-1:0]                        byteEn;

  apb_regbank_decoder #(
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .APB_DATA_WIDTH (APB_DATA_WIDTH),
    .NUM_REGS       (NUM_REGS),
    .BASE_ADDR      (BASE_ADDR),
    .RO_MASK        (RO_MASK)
  ) u_decoder (
    .paddr  (paddr),
    .pwrite (pwrite),
    .idx    (decIdx),
    .hit    (decHit),
    .ro_err (decRoErr)
  );

  assign decErr   = !decHit || decRoErr;
  assign sts      = sts_in;
  assign ctrl_out = regs;

  // Read data comes from the live decode when a zero-wait transfer jumps straight to DONE.
  always_comb begin
    rdIdx  = (state == IDLE) ? decIdx : idxQ;
    rdData = RO_MASK[rdIdx] ? sts[rdIdx] : regs[rdIdx];
`ifdef APB_REGBANK_PSTRB_EN
    byteEn = pstrb;
`else
    byteEn = pstrb | {STRB_W{1'b1}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idxQ     <= '0;
      writeQ   <= 1'b0;
      errQ     <= 1'b0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_pulse <= '0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            idxQ   <= decIdx;
            writeQ <= pwrite;
            errQ   <= decErr;
            if (WAIT_STATES == 0) begin
              state   <= DONE;
              pready  <= 1'b1;
              pslverr <= decErr;
              prdata  <= (decErr || pwrite) ? '0 : rdData;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state   <= DONE;
            pready  <= 1'b1;
            pslverr <= errQ;
            prdata  <= (errQ || writeQ) ? '0 : rdData;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          // Commit only if the master is still in ACCESS; RO slots never take data.
          if (psel && penable && pwrite && writeQ && !errQ && !RO_MASK[idxQ] && (|byteEn)) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (byteEn[b]) regs[idxQ][8*b +: 8] <= pwdata[8*b +: 8];
            end
            wr_pulse[idxQ] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
- Parametrised APB slave endpoint with a register bank. Successor to the plain APB signal bundle.
- Adds address decode, a configurable wait-state counter, an error response, and read-only (status) registers.
- Sits between the APB fabric and a peripheral core (e.g. the I2S transmitter). It exports control registers as flat vectors and imports status words.

Parameters:
- APB_ADDR_WIDTH, 32, width of paddr.
- APB_DATA_WIDTH, 32, width of pwdata/prdata. Must be 8, 16 or 32.
- NUM_REGS, 8, number of word registers (1..64).
- BASE_ADDR, 0, byte address of register 0. Must be aligned to NUM_REGS*APB_DATA_WIDTH/8.
- RO_MASK, 0, NUM_REGS-bit mask. Bit i=1 makes register i read-only, sourced from sts_in.
- WAIT_STATES, 0, number of pready-low ACCESS cycles per transfer (0..15).
- RESET_VAL, 0, reset value of every read/write register.

Ports:
- clk  in  1  APB clock (PCLK).
- rst_n  in  1  asynchronous active-low reset.
- paddr  in  APB_ADDR_WIDTH  byte address.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- pwdata  in  APB_DATA_WIDTH  write data.
- pstrb  in  APB_DATA_WIDTH/8  byte strobes (used only with APB_REGBANK_PSTRB_EN).
- prdata  out  APB_DATA_WIDTH  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  error response.
- ctrl_out  out  NUM_REGS*APB_DATA_WIDTH  register contents, register i at slice i.
- sts_in  in  NUM_REGS*APB_DATA_WIDTH  status words, read for RO registers.
- wr_pulse  out  NUM_REGS  one-cycle pulse per committed write.

Behaviour:
- Reset: clk single clock; rst_n async assert, sync deassert upstream.
  - pready=0, pslverr=0, prdata=0, wr_pulse=0.
  - RW registers = RESET_VAL; FSM = IDLE.
- Decode: offset = paddr - BASE_ADDR; idx = offset >> log2(APB_DATA_WIDTH/8).
  - Error if offset is misaligned, idx >= NUM_REGS, or the access is a write to an RO register.
- FSM states IDLE, WAIT, DONE. All outputs are registered.
  - IDLE: on psel & !penable (SETUP), latch the decoded idx, pwrite and error flag. Go to DONE if WAIT_STATES==0, else go to WAIT with cnt=WAIT_STATES.
  - WAIT: cnt decrements each cycle. Go to DONE when cnt==1.
  - DONE: pready=1 for exactly one cycle, then IDLE.
- Resulting latency: pready is high in ACCESS cycle number WAIT_STATES+1, counted from the first ACCESS cycle.
- Read: prdata is loaded on the edge entering DONE, from ctrl reg or sts_in (RO), sampled at that edge. prdata=0 in every other cycle and on error.
- Write: commits on the edge leaving DONE, only when psel&penable&pwrite&!err. wr_pulse[idx]=1 in the following cycle only.
- pslverr is asserted only together with pready on an errored transfer. An errored write has no side effect; an errored read returns 0.
- Back-to-back: a SETUP in the cycle after DONE is accepted from IDLE with no bubble.
- Protocol violations:
  - psel dropped during WAIT or DONE: abort to IDLE, no commit, pready/pslverr cleared next cycle.
  - penable without psel: ignored.
- Reset mid-transfer: everything returns immediately to reset values; no partial write.
- RO registers ignore writes even without error reporting.

Optional Feature:
- Macro APB_REGBANK_PSTRB_EN.
  - Defined: the write updates only the bytes whose pstrb bit is 1. pstrb==0 still completes, with no data change and no wr_pulse.
  - Undefined: pstrb is ignored and every write updates the full word.

Decomposition:
- Package apb_regbank_pkg holds:
  - typedef fsm_state_e {IDLE, WAIT, DONE};
  - function addr_to_idx;
  - localparam BYTES_PER_WORD.
- One sub-module, apb_regbank_decoder: combinational decode of paddr to idx, hit, and ro_err.

Test Plan:
- WAIT_STATES=0, write 0xA5A5_0001 to 0x04, then read 0x04. Expect:
  - pready high in the first ACCESS cycle;
  - ctrl_out[63:32]=0xA5A5_0001;
  - wr_pulse[1] high for one cycle;
  - prdata=0xA5A5_0001, pslverr=0.
- WAIT_STATES=3, read 0x00. Expect pready low for 3 ACCESS cycles and high on the 4th; prdata=RESET_VAL only in that cycle.
- Access 0x20 with NUM_REGS=8 (out of range), and 0x02 (misaligned). Expect pslverr=1 with pready, prdata=0, no register change.
- RO_MASK=8'h04, sts_in reg2=0xDEAD_BEEF. Expect a read of 0x08 to return 0xDEAD_BEEF, and a write to 0x08 to give pslverr=1 with ctrl unchanged.
- With APB_REGBANK_PSTRB_EN, write 0xFFFF_FFFF with pstrb=4'b0010 to 0x0C (reg=0). Expect reg3=0x0000_FF00.
- Assert rst_n low during the WAIT of a write to 0x04 holding 0x1234. Expect reg1=RESET_VAL, pready=0, and a subsequent transfer completing normally.
